// File: rtl/dyser_in_port.sv
// dyser_in_port: credit-based injection port feeding processor words into the DySER fabric.
// Define DYSER_IN_PORT_BYPASS_EN to let a word skip an empty FIFO straight onto d_out.
`ifndef PATH_WIDTH
`define PATH_WIDTH 8
`endif

module dyser_in_port #(
   parameter int DEPTH   = 4,
   parameter int CREDITS = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [`PATH_WIDTH-1:0]  in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [`PATH_WIDTH:0]    d_out,
   input  logic                    c_in,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic [3:0]              credit_cnt,
   output logic                    credit_err
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   DEPTH_C   = (PW+1)'(DEPTH);
   localparam logic [PW:0]   CNT_ZERO  = (PW+1)'(0);
   localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [3:0]    CREDITS_C = 4'(CREDITS);

   logic [`PATH_WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]          wr_ptr_r;
   logic [PW-1:0]          rd_ptr_r;
   logic [PW:0]            count_r;
   logic [3:0]             credit_r;
   logic                   err_r;
   logic [`PATH_WIDTH:0]   d_out_r;

   logic                   in_ready_s;
   logic                   push_s;
   logic                   send_s;
   logic                   bypass_s;
   logic                   fifo_wr_s;
   logic [PW:0]            count_nxt_s;
   logic [3:0]             credit_nxt_s;
   logic                   err_nxt_s;

   // Transfer decisions for this edge, derived from registered state and rst only
   always_comb begin
      in_ready_s = (count_r < DEPTH_C) && !rst;
      push_s     = in_valid && in_ready_s;
      send_s     = (count_r != CNT_ZERO) && (credit_r != 4'd0);
`ifdef DYSER_IN_PORT_BYPASS_EN
      bypass_s   = push_s && (count_r == CNT_ZERO) && (credit_r != 4'd0);
`else
      bypass_s   = 1'b0;
`endif
      fifo_wr_s  = push_s && !bypass_s;
   end

   // Next occupancy and credit state; a return with a full credit pool is an overflow
   always_comb begin
      count_nxt_s  = count_r;
      credit_nxt_s = credit_r;
      err_nxt_s    = err_r;
      case ({fifo_wr_s, send_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
      case ({c_in, (send_s || bypass_s)})
         2'b10: begin
            if (credit_r == CREDITS_C) begin
               err_nxt_s = 1'b1;
            end else begin
               credit_nxt_s = credit_r + 4'd1;
            end
         end
         2'b01:   credit_nxt_s = credit_r - 4'd1;
         default: credit_nxt_s = credit_r;
      endcase
   end

   // Payload storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (!rst && fifo_wr_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

   // Pointers, counters, credit pool and the registered fabric beat
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
         credit_r <= CREDITS_C;
         err_r    <= 1'b0;
         d_out_r  <= {(`PATH_WIDTH+1){1'b0}};
      end else begin
         if (fifo_wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (send_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
            d_out_r  <= {mem_r[rd_ptr_r], 1'b1};
         end else if (bypass_s) begin
            d_out_r  <= {in_data, 1'b1};
         end else begin
            d_out_r  <= {(`PATH_WIDTH+1){1'b0}};
         end
         count_r  <= count_nxt_s;
         credit_r <= credit_nxt_s;
         err_r    <= err_nxt_s;
      end
   end

   assign in_ready   = in_ready_s;
   assign d_out      = d_out_r;
   assign fifo_count = count_r;
   assign credit_cnt = credit_r;
   assign credit_err = err_r;

endmodule

// File: tb/tb_dyser_in_port.sv
// Self-checking bench for dyser_in_port: queue-based reference model plus directed pins.
`ifndef PATH_WIDTH
`define PATH_WIDTH 8
`endif

module tb_dyser_in_port;
   localparam int DEPTH   = 4;
   localparam int CREDITS = 2;
   localparam int W       = `PATH_WIDTH;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [W-1:0]   in_data = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W:0]     d_out;
   logic           c_in = 1'b0;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [3:0]     credit_cnt;
   logic           credit_err;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // reference model state
   logic [W-1:0] q[$];
   int           m_credit = CREDITS;
   bit           m_err = 1'b0;
   logic [W:0]   m_dout = '0;
   logic [W:0]   beats[$];

   dyser_in_port #(.DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .d_out(d_out), .c_in(c_in),
      .fifo_count(fifo_count), .credit_cnt(credit_cnt), .credit_err(credit_err)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one rising edge using the inputs held across it
   task automatic model_step();
      bit ready, send, byp;
      if (rst) begin
         q.delete();
         m_credit = CREDITS;
         m_err    = 1'b0;
         m_dout   = '0;
      end else begin
         ready = (q.size() < DEPTH);
         send  = (q.size() > 0) && (m_credit > 0);
         byp   = 1'b0;
`ifdef DYSER_IN_PORT_BYPASS_EN
         byp   = in_valid && ready && (q.size() == 0) && (m_credit > 0);
`endif
         if (send)     m_dout = {q.pop_front(), 1'b1};
         else if (byp) m_dout = {in_data, 1'b1};
         else          m_dout = '0;
         if (in_valid && ready && !byp) q.push_back(in_data);
         if (c_in && !(send || byp)) begin
            if (m_credit == CREDITS) m_err = 1'b1;
            else m_credit++;
         end else if (!c_in && (send || byp)) begin
            m_credit--;
         end
      end
   endtask

   task automatic cycle(bit v, logic [W-1:0] d, bit c, bit r);
      in_valid = v;
      in_data  = d;
      c_in     = c;
      rst      = r;
      @(posedge clk);
      model_step();
      #1;
      if (d_out[0] === 1'b1) beats.push_back(d_out);
   endtask

   function automatic logic [W:0] beat_at(int i);
      if (i < beats.size()) return beats[i];
      else return 'x;
   endfunction

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("d_out", 32'(d_out), 32'(m_dout));
         check("fifo_count", 32'(fifo_count), 32'(q.size()));
         check("credit_cnt", 32'(credit_cnt), 32'(m_credit));
         check("credit_err", 32'(credit_err), 32'(m_err));
         check("in_ready", 32'(in_ready), 32'((q.size() < DEPTH) && !rst));
      end
   end

   initial begin
      cycle(1'b1, 8'hFF, 1'b1, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk_en = 1'b1;

      // reset state
      rst = 1'b0;
      #1;
      check("rst_d_out", 32'(d_out), 32'h0);
      check("rst_credit", 32'(credit_cnt), 32'd2);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_err", 32'(credit_err), 32'd0);

      // three pushes, two credits
      beats.delete();
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      cycle(1'b1, 8'h3C, 1'b0, 1'b0);
      cycle(1'b1, 8'h77, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      check("seq_nbeats", 32'(beats.size()), 32'd2);
      check("seq_beat0", 32'(beat_at(0)), 32'h14B);
      check("seq_beat1", 32'(beat_at(1)), 32'h079);
      check("seq_credit0", 32'(credit_cnt), 32'd0);
      check("seq_held", 32'(fifo_count), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("credit_edge_idle", 32'(d_out), 32'h0);
      check("credit_back", 32'(credit_cnt), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      check("held_out", 32'(d_out), 32'h0EF);

      // fill to full, then drain with four credit pulses
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
      check("full_count", 32'(fifo_count), 32'd4);
      check("full_ready", 32'(in_ready), 32'd0);
      cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      check("full_ignore", 32'(fifo_count), 32'd4);
      beats.delete();
      for (int k = 0; k < 4; k++) begin
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
         cycle(1'b0, 8'h00, 1'b0, 1'b0);
      end
      check("drain_nbeats", 32'(beats.size()), 32'd4);
      check("drain_b0", 32'(beat_at(0)), 32'h067);
      check("drain_b1", 32'(beat_at(1)), 32'h089);
      check("drain_b2", 32'(beat_at(2)), 32'h0AB);
      check("drain_b3", 32'(beat_at(3)), 32'h0CD);
      check("drain_empty", 32'(fifo_count), 32'd0);

      // credit return coinciding with a send, then overflow
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef DYSER_IN_PORT_BYPASS_EN
      cycle(1'b1, 8'hC3, 1'b1, 1'b0);
`else
      cycle(1'b1, 8'hC3, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
`endif
      check("send_cin_out", 32'(d_out), 32'h187);
      check("send_cin_credit", 32'(credit_cnt), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("refill_credit", 32'(credit_cnt), 32'd2);
      check("refill_noerr", 32'(credit_err), 32'd0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("ovf_err", 32'(credit_err), 32'd1);
      check("ovf_credit", 32'(credit_cnt), 32'd2);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      check("ovf_sticky", 32'(credit_err), 32'd1);

      // reset mid-stream discards held words
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
      check("pre_rst_count", 32'(fifo_count), 32'd3);
      beats.delete();
      cycle(1'b1, 8'hE1, 1'b1, 1'b1);
      check("rst_cycle_ready", 32'(in_ready), 32'd0);
      check("mid_rst_count", 32'(fifo_count), 32'd0);
      check("mid_rst_dout", 32'(d_out), 32'h0);
      check("mid_rst_credit", 32'(credit_cnt), 32'd2);
      check("mid_rst_err", 32'(credit_err), 32'd0);
      cycle(1'b1, 8'h42, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      check("post_rst_nbeats", 32'(beats.size()), 32'd1);
      check("post_rst_beat", 32'(beat_at(0)), 32'h085);

      // latency from an empty port with credit
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b1, 8'h01, 1'b0, 1'b0);
`ifdef DYSER_IN_PORT_BYPASS_EN
      check("lat_edge1", 32'(d_out), 32'h003);
`else
      check("lat_edge1", 32'(d_out), 32'h000);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      check("lat_edge2", 32'(d_out), 32'h003);
`endif

      // randomized traffic with varying credit pressure
      for (int n = 0; n < 3000; n++) begin
         int cp;
         cp = ((n / 300) % 2 == 0) ? 4 : 1;
         cycle(($urandom % 10) < 6, 8'($urandom), ($urandom % 10) < cp,
               ($urandom_range(0, 249) == 0));
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dyser_in_port.md
DYSER_IN_PORT -- requirements
Module: dyser_in_port

Interface
REQ-001 Parameter DEPTH, default 4: payload FIFO entries; power of two, 2..16.
REQ-002 Parameter CREDITS, default 2: initial and maximum downstream credits; 1..15.
REQ-003 clk  input  1  single clock; every register updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  `PATH_WIDTH  payload word from the processor side.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  a word is accepted on a rising edge where in_valid && in_ready.
REQ-008 d_out  output  `PATH_WIDTH+1  fabric data: bit 0 is the valid bit, bits [`PATH_WIDTH:1] are the payload; connects to a switch d_in_* port.
REQ-009 c_in  input  1  credit return pulse from the switch c_out_* port; each cycle high returns one credit.
REQ-010 fifo_count  output  $clog2(DEPTH)+1  number of words held in the FIFO.
REQ-011 credit_cnt  output  4  credits currently available.
REQ-012 credit_err  output  1  sticky flag for credit overflow.

Function
REQ-013 in_ready SHALL be (fifo_count < DEPTH) && !rst; it is combinational from registered state only.
REQ-014 Accepted words SHALL leave the block in FIFO order; no word is dropped or duplicated.
REQ-015 d_out SHALL be registered; each cycle it is loaded with {head, 1'b1} (send) or all zeros (idle).
REQ-016 A send SHALL occur on an edge when the FIFO is non-empty and credit_cnt > 0; the head is popped in the same edge.
REQ-017 Each valid beat on d_out SHALL last exactly one cycle; back-to-back sends are allowed while words and credits last.
REQ-018 credit_cnt next value: +1 on c_in only, -1 on send only, unchanged on send && c_in together.
REQ-019 c_in while credit_cnt == CREDITS with no send SHALL leave credit_cnt at CREDITS and set credit_err; credit_err stays set until rst.
REQ-020 With credit_cnt == 0, no send SHALL occur; a c_in in that cycle takes effect at the edge, so a send can occur on the next edge at the earliest.
REQ-021 When full, a push and a pop in the same cycle cannot happen because in_ready is low; when not full, a simultaneous push and pop leaves fifo_count unchanged.
REQ-022 Without bypass (REQ-028), latency from accepting edge N to the valid beat on d_out SHALL be 2 edges: the FIFO write is at N and d_out is loaded at N+1, given credit.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH with no bubble at the wrap.

Reset
REQ-024 While rst is high at an edge: fifo_count=0, pointers=0, d_out=0, credit_cnt=CREDITS, credit_err=0.
REQ-025 in_valid and c_in SHALL be ignored in any cycle where rst is high; in_ready is 0 in that cycle.
REQ-026 A reset asserted mid-stream SHALL discard FIFO contents and any pending beat; d_out is 0 on the following cycle.
REQ-027 The first acceptance SHALL be possible on the first edge after rst deasserts.

Configuration
REQ-028 Macro DYSER_IN_PORT_BYPASS_EN, when defined: if the FIFO is empty, credit_cnt > 0 and in_valid && in_ready, the word SHALL load d_out directly at the accepting edge (latency 1) without entering the FIFO.
REQ-029 With the macro undefined: no bypass path exists; all words pass through the FIFO (latency 2); all other behaviour is identical.

Verification
REQ-030 Reset, then check: d_out=0, credit_cnt=2, fifo_count=0, in_ready=1, credit_err=0.
REQ-031 Push 0xA5, 0x3C and 0x77 on consecutive cycles with c_in=0 -> 0xA5 and 0x3C go out on consecutive cycles with bit 0=1; credit_cnt=0; 0x77 is held (fifo_count=1); pulse c_in once -> 0x77 goes out on the edge after the credit edge.
REQ-032 Push 5 words with no credits after the first 2 sends -> in_ready drops when fifo_count=4; pulse c_in 4 times -> all words are delivered in order; the pointers wrap correctly.
REQ-033 Hold c_in high during a send cycle with credit_cnt=1 -> credit_cnt stays 1; with no send and credit_cnt=2, pulse c_in -> credit_err=1 and credit_cnt=2.
REQ-034 Assert rst with fifo_count=3 -> next cycle fifo_count=0, d_out=0, credit_cnt=2; none of those words ever appears.
REQ-035 Latency check: push 0x1 into an empty port with credit -> valid beat 2 edges later without DYSER_IN_PORT_BYPASS_EN, 1 edge later with it.
